// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, funct codes,
// ALU control codes, datapath mux encodings and FSM state codes.
package mips_pkg;

  localparam int unsigned OpW     = 6;
  localparam int unsigned FunctW  = 6;
  localparam int unsigned AluCtlW = 3;
  localparam int unsigned StateW  = 4;
  localparam int unsigned SrcBW   = 2;
  localparam int unsigned PcSrcW  = 2;

  // Opcodes (Instr[31:26])
  localparam logic [OpW-1:0] OpRType = 6'b000000;
  localparam logic [OpW-1:0] OpLw    = 6'b100011;
  localparam logic [OpW-1:0] OpSw    = 6'b101011;
  localparam logic [OpW-1:0] OpBeq   = 6'b000100;
  localparam logic [OpW-1:0] OpAddi  = 6'b001000;
  localparam logic [OpW-1:0] OpOri   = 6'b001101;
  localparam logic [OpW-1:0] OpJ     = 6'b000010;

  // R-type function codes (Instr[5:0])
  localparam logic [FunctW-1:0] FnAdd = 6'b100000;
  localparam logic [FunctW-1:0] FnSub = 6'b100010;
  localparam logic [FunctW-1:0] FnAnd = 6'b100100;
  localparam logic [FunctW-1:0] FnOr  = 6'b100101;
  localparam logic [FunctW-1:0] FnSlt = 6'b101010;

  // ALU control codes
  localparam logic [AluCtlW-1:0] AluAdd = 3'b010;
  localparam logic [AluCtlW-1:0] AluSub = 3'b110;
  localparam logic [AluCtlW-1:0] AluAnd = 3'b000;
  localparam logic [AluCtlW-1:0] AluOr  = 3'b001;
  localparam logic [AluCtlW-1:0] AluSlt = 3'b111;

  // ALU B-operand select
  localparam logic [SrcBW-1:0] SrcBRegB  = 2'b00;
  localparam logic [SrcBW-1:0] SrcBFour  = 2'b01;
  localparam logic [SrcBW-1:0] SrcBImm   = 2'b10;
  localparam logic [SrcBW-1:0] SrcBImmSh = 2'b11;

  // Next-PC source select
  localparam logic [PcSrcW-1:0] PcSrcAlu    = 2'b00;
  localparam logic [PcSrcW-1:0] PcSrcAluOut = 2'b01;
  localparam logic [PcSrcW-1:0] PcSrcJump   = 2'b10;

  typedef enum logic [StateW-1:0] {
    Fetch   = 4'd0,
    Decode  = 4'd1,
    MemAdr  = 4'd2,
    MemRd   = 4'd3,
    MemWb   = 4'd4,
    MemWr   = 4'd5,
    Execute = 4'd6,
    AluWb   = 4'd7,
    Branch  = 4'd8,
    ImmEx   = 4'd9,
    ImmWb   = 4'd10,
    Jump    = 4'd11
  } stateT;

  // True for every opcode the controller executes; others retire in DECODE.
  function automatic logic opSupported(input logic [OpW-1:0] op);
    return (op == OpLw) || (op == OpSw) || (op == OpRType) || (op == OpBeq) ||
           (op == OpAddi) || (op == OpOri) || (op == OpJ);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational R-type ALU decoder.
// Ports: Funct (instruction function field) -> AluCtl (ALU operation code).
module alu_decoder
  import mips_pkg::*;
(
  input  logic [FunctW-1:0]  Funct,
  output logic [AluCtlW-1:0] AluCtl
);

  // Unknown funct codes fall back to add.
  always_comb begin
    AluCtl = AluAdd;
    case (Funct)
      FnAdd:   AluCtl = AluAdd;
      FnSub:   AluCtl = AluSub;
      FnAnd:   AluCtl = AluAnd;
      FnOr:    AluCtl = AluOr;
      FnSlt:   AluCtl = AluSlt;
      default: AluCtl = AluAdd;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute.
// Ports:
//   CLK, Reset          clock and synchronous active-high reset
//   Op, Funct, Zero     opcode, function field, ALU zero flag
//   IorD .. ExtOp       datapath selects and write enables
//   Done                high in the final cycle of each instruction
//   State               current state code (debug)
module multicycle_controller
  import mips_pkg::*;
(
  input  logic                CLK,
  input  logic                Reset,
  input  logic [OpW-1:0]      Op,
  input  logic [FunctW-1:0]   Funct,
  input  logic                Zero,
  output logic                IorD,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                RegWrite,
  output logic                RegDst,
  output logic                MemToReg,
  output logic                AluSrcA,
  output logic [SrcBW-1:0]    AluSrcB,
  output logic [AluCtlW-1:0]  AluCtl,
  output logic [PcSrcW-1:0]   PCSrc,
  output logic                PCEn,
  output logic                ExtOp,
  output logic                Done,
  output logic [StateW-1:0]   State
);

  stateT                state;
  logic [AluCtlW-1:0]   functCtl;
  logic                 irWriteRaw;
  logic                 pcEnRaw;

  alu_decoder uAluDecoder (
    .Funct  (Funct),
    .AluCtl (functCtl)
  );

  // State register with next-state selection; reset wins over any transition.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= Fetch;
    end else begin
      case (state)
        Fetch:   state <= Decode;
        Decode: begin
          case (Op)
            OpLw, OpSw:    state <= MemAdr;
            OpRType:       state <= Execute;
            OpBeq:         state <= Branch;
            OpAddi, OpOri: state <= ImmEx;
            OpJ:           state <= Jump;
            default:       state <= Fetch;
          endcase
        end
        MemAdr:  state <= (Op == OpSw) ? MemWr : MemRd;
        MemRd:   state <= MemWb;
        Execute: state <= AluWb;
        ImmEx:   state <= ImmWb;
        default: state <= Fetch;
      endcase
    end
  end

  // Per-state output decode; unused codes keep all enables low.
  always_comb begin
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    irWriteRaw = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemToReg   = 1'b0;
    AluSrcA    = 1'b0;
    AluSrcB    = SrcBRegB;
    AluCtl     = AluAdd;
    PCSrc      = PcSrcAlu;
    pcEnRaw    = 1'b0;
    Done       = 1'b0;
    case (state)
      Fetch: begin
        AluSrcB    = SrcBFour;
        irWriteRaw = 1'b1;
        pcEnRaw    = 1'b1;
      end
      Decode: begin
        AluSrcB = SrcBImmSh;
        Done    = ~opSupported(Op);
      end
      MemAdr: begin
        AluSrcA = 1'b1;
        AluSrcB = SrcBImm;
      end
      MemRd: IorD = 1'b1;
      MemWb: begin
        MemToReg = 1'b1;
        RegWrite = 1'b1;
        Done     = 1'b1;
      end
      MemWr: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        Done     = 1'b1;
      end
      Execute: begin
        AluSrcA = 1'b1;
        AluCtl  = functCtl;
      end
      AluWb: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        Done     = 1'b1;
      end
      Branch: begin
        AluSrcA = 1'b1;
        AluCtl  = AluSub;
        PCSrc   = PcSrcAluOut;
        pcEnRaw = Zero;
        Done    = 1'b1;
      end
      ImmEx: begin
        AluSrcA = 1'b1;
        AluSrcB = SrcBImm;
        AluCtl  = (Op == OpOri) ? AluOr : AluAdd;
      end
      ImmWb: begin
        RegWrite = 1'b1;
        Done     = 1'b1;
      end
      Jump: begin
        PCSrc   = PcSrcJump;
        pcEnRaw = 1'b1;
        Done    = 1'b1;
      end
      default: ;
    endcase
  end

  // While reset is held the PC and IR must not load.
  assign IRWrite = irWriteRaw & ~Reset;
  assign PCEn    = pcEnRaw & ~Reset;
  assign ExtOp   = (Op != OpOri);
  assign State   = StateW'(state);

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed instruction cases
// plus randomized instruction streams compared against a per-instruction
// reference model (state path from latency table, outputs from per-state rules).
module tb_multicycle_controller;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       IorD, MemWrite, IRWrite, RegWrite, RegDst, MemToReg, AluSrcA;
  logic [1:0] AluSrcB;
  logic [2:0] AluCtl;
  logic [1:0] PCSrc;
  logic       PCEn, ExtOp, Done;
  logic [3:0] State;

  int unsigned nVec = 0;
  int unsigned nBad = 0;

  multicycle_controller dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .Op       (Op),
    .Funct    (Funct),
    .Zero     (Zero),
    .IorD     (IorD),
    .MemWrite (MemWrite),
    .IRWrite  (IRWrite),
    .RegWrite (RegWrite),
    .RegDst   (RegDst),
    .MemToReg (MemToReg),
    .AluSrcA  (AluSrcA),
    .AluSrcB  (AluSrcB),
    .AluCtl   (AluCtl),
    .PCSrc    (PCSrc),
    .PCEn     (PCEn),
    .ExtOp    (ExtOp),
    .Done     (Done),
    .State    (State)
  );

  always #5 CLK = ~CLK;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Instruction length in cycles, straight from the latency table.
  function automatic int pathLen(input logic [5:0] op);
    case (op)
      6'b100011:            return 5;
      6'b101011:            return 4;
      6'b000000:            return 4;
      6'b001000, 6'b001101: return 4;
      6'b000100:            return 3;
      6'b000010:            return 3;
      default:              return 2;
    endcase
  endfunction

  // State visited in cycle i of an instruction.
  function automatic int pathState(input logic [5:0] op, input int i);
    if (i == 0) return 0;
    if (i == 1) return 1;
    case (op)
      6'b100011:            return (i == 2) ? 2 : (i == 3) ? 3 : 4;
      6'b101011:            return (i == 2) ? 2 : 5;
      6'b000000:            return (i == 2) ? 6 : 7;
      6'b001000, 6'b001101: return (i == 2) ? 9 : 10;
      6'b000100:            return 8;
      6'b000010:            return 11;
      default:              return 0;
    endcase
  endfunction

  function automatic logic [2:0] functCode(input logic [5:0] f);
    if (f == 6'h20) return 3'b010;
    if (f == 6'h22) return 3'b110;
    if (f == 6'h24) return 3'b000;
    if (f == 6'h25) return 3'b001;
    if (f == 6'h2a) return 3'b111;
    return 3'b010;
  endfunction

  // Expected output vector for a state, built from the per-state output rules.
  function automatic logic [31:0] expOut(input int s, input logic [5:0] op,
                                         input logic [5:0] funct, input logic zero,
                                         input logic rst);
    logic       iord, memW, irW, regW, regDst, m2r, srcA, pcEn, ext, done;
    logic [1:0] srcB, pcSrc;
    logic [2:0] alu;
    iord   = (s == 3) || (s == 5);
    memW   = (s == 5);
    irW    = (s == 0) && !rst;
    regW   = (s == 4) || (s == 7) || (s == 10);
    regDst = (s == 7);
    m2r    = (s == 4);
    srcA   = (s == 2) || (s == 6) || (s == 8) || (s == 9);
    srcB   = (s == 0) ? 2'b01 : (s == 1) ? 2'b11 : ((s == 2) || (s == 9)) ? 2'b10 : 2'b00;
    alu    = (s == 6) ? functCode(funct) : (s == 8) ? 3'b110 :
             (s == 9) ? ((op == 6'b001101) ? 3'b001 : 3'b010) : 3'b010;
    pcSrc  = (s == 8) ? 2'b01 : (s == 11) ? 2'b10 : 2'b00;
    pcEn   = !rst && ((s == 0) || (s == 11) || ((s == 8) && zero));
    ext    = (op != 6'b001101);
    done   = (s == 4) || (s == 5) || (s == 7) || (s == 8) || (s == 10) || (s == 11) ||
             ((s == 1) && (pathLen(op) == 2));
    return {11'b0, 4'(s), iord, memW, irW, regW, regDst, m2r, srcA, srcB, alu, pcSrc, pcEn, ext, done};
  endfunction

  function automatic logic [31:0] obsOut();
    return {11'b0, State, IorD, MemWrite, IRWrite, RegWrite, RegDst, MemToReg, AluSrcA,
            AluSrcB, AluCtl, PCSrc, PCEn, ExtOp, Done};
  endfunction

  // One cycle: drive inputs after the falling edge, check, then cross the rising edge.
  task automatic doCycle(input int s, input logic [5:0] op, input logic [5:0] funct,
                         input logic zero, input logic rst, input string tag);
    Op = op; Funct = funct; Zero = zero; Reset = rst;
    #1;
    checkVal({tag, "/out"}, obsOut(), expOut(s, op, funct, zero, rst));
    checkVal({tag, "/wen"}, 32'($countones({RegWrite, MemWrite, IRWrite}) > 1), 32'd0);
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Run one instruction; zeroMode < 0 randomizes Zero, rstAt >= 0 aborts with reset.
  task automatic runInstr(input logic [5:0] op, input logic [5:0] funct,
                          input int zeroMode, input int rstAt, input string tag);
    int  n;
    logic z, r;
    n = pathLen(op);
    for (int i = 0; i < n; i++) begin
      z = (zeroMode < 0) ? 1'($urandom % 2) : 1'(zeroMode);
      r = (i == rstAt);
      doCycle(pathState(op, i), op, funct, z, r, tag);
      if (r) break;
    end
  endtask

  logic [5:0] opList [8];
  logic [5:0] fnList [5];

  initial begin
    opList = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b001101, 6'b000010, 6'b111111};
    fnList = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    Reset = 1'b1; Op = '0; Funct = '0; Zero = 1'b0;
    @(posedge CLK);
    @(negedge CLK);

    // Held reset shows FETCH with PC/IR loads suppressed.
    doCycle(0, 6'b100011, 6'h00, 1'b0, 1'b1, "rst0");
    doCycle(0, 6'b100011, 6'h00, 1'b0, 1'b1, "rst1");

    runInstr(6'b100011, 6'h00, 0, -1, "lw");
    runInstr(6'b000100, 6'h00, 1, -1, "beqTaken");
    runInstr(6'b000100, 6'h00, 0, -1, "beqNotTaken");
    runInstr(6'b000000, 6'h2a, -1, -1, "rSlt");
    runInstr(6'b000000, 6'h3f, -1, -1, "rBadFunct");
    runInstr(6'b000000, 6'h22, -1, -1, "rSub");
    runInstr(6'b001101, 6'h00, -1, -1, "ori");
    runInstr(6'b001000, 6'h00, -1, -1, "addi");
    runInstr(6'b111111, 6'h00, -1, -1, "unsupported");
    runInstr(6'b101011, 6'h00, -1, 3, "swReset");
    runInstr(6'b000010, 6'h00, -1, -1, "jAfterReset");
    runInstr(6'b100011, 6'h00, -1, 2, "lwReset");
    runInstr(6'b101011, 6'h00, -1, -1, "sw");

    for (int k = 0; k < 300; k++) begin
      logic [5:0] op, fn;
      int         rAt;
      op  = ($urandom % 10 == 0) ? 6'($urandom) : opList[$urandom % 8];
      fn  = ($urandom % 4 == 0) ? 6'($urandom) : fnList[$urandom % 5];
      rAt = ($urandom % 12 == 0) ? int'($urandom % pathLen(op)) : -1;
      runInstr(op, fn, -1, rAt, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
